// File: rtl/ram_banked.sv
// ram_banked
// Banked, byte-writable, true-dual-port RAM with a hardware clear engine.
// NUM_BANKS independent tables of 2**ADDR_WIDTH words sit behind two
// single-clock ports (A and B).
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   clear             one-cycle request to re-run the clear sweep (needs ready=1)
//   ready             1 when port requests are accepted, 0 during a sweep
//   x_en, x_we        request strobe, 1 = write / 0 = read (x = a or b)
//   x_be              byte enables for writes
//   x_bank, x_addr    bank select and word address within the bank
//   x_din             write data
//   x_dout, x_valid   read data (held between reads) and its one-cycle valid
//   collision         pulses one cycle after port B's write was dropped
module ram_banked #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    NUM_BANKS    = 4,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITE_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
  localparam int                   BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int                   BE_W         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [BE_W-1:0]       a_be,
  input  logic [BANK_W-1:0]     a_bank,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [BE_W-1:0]       b_be,
  input  logic [BANK_W-1:0]     b_bank,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic                    sweep_we, ready_next, clear_go;
  logic [DATA_WIDTH-1:0]   mem [NUM_BANKS][DEPTH];

  logic                    a_acc, b_acc, a_wr, b_wr, b_drop;
  logic [DATA_WIDTH-1:0]   a_mask, b_mask, a_old, b_old, a_merged, b_merged;
  logic                    a_req_valid, b_req_valid;
  logic [DATA_WIDTH-1:0]   a_req_data, b_req_data;
  logic                    a_s1_valid, b_s1_valid;
  logic [DATA_WIDTH-1:0]   a_s1_data, b_s1_data;

  // ready=1 implies the FSM is idle, so a honoured clear never overlaps a sweep.
  assign clear_go = clear && ready;

  // Clear-engine state register, sweep counter and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      ready      <= 1'b0;
    end else begin
      state <= state_next;
      ready <= ready_next;
      if (clear_go)
        sweep_addr <= '0;
      else if (state == ST_CLEAR)
        sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (sweep_addr == {ADDR_WIDTH{1'b1}}) state_next = ST_IDLE;
      ST_IDLE:  if (clear_go) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // ready lags entry into IDLE by one cycle, but drops on the same edge that
  // accepts a clear so no port request lands after the sweep has begun.
  always_comb begin
    sweep_we   = (state == ST_CLEAR);
    ready_next = (state == ST_IDLE) && !clear_go;
  end

  assign a_acc  = a_en && ready;
  assign b_acc  = b_en && ready;
  assign a_wr   = a_acc && a_we;
  assign b_wr   = b_acc && b_we;
  assign b_drop = a_wr && b_wr && (a_bank == b_bank) && (a_addr == b_addr);

  assign a_old    = mem[a_bank][a_addr];
  assign b_old    = mem[b_bank][b_addr];
  assign a_merged = (a_old & ~a_mask) | (a_din & a_mask);
  assign b_merged = (b_old & ~b_mask) | (b_din & b_mask);

  always_comb begin
    a_mask = '0;
    b_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      a_mask[i*8 +: 8] = {8{a_be[i]}};
      b_mask[i*8 +: 8] = {8{b_be[i]}};
    end
  end

  // Memory array is deliberately not reset; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      for (int bk = 0; bk < NUM_BANKS; bk++)
        mem[bk][sweep_addr] <= CLEAR_VALUE;
    end
    for (int i = 0; i < BE_W; i++) begin
      if (b_wr && !b_drop && b_be[i])
        mem[b_bank][b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
      if (a_wr && a_be[i])
        mem[a_bank][a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
    end
  end

  // In write-first mode a write with any enabled lane reports the merged word
  // like a read. A dropped port-B write reports nothing.
  always_comb begin
    a_req_valid = a_acc && (!a_we || ((WRITE_MODE == 0) && (|a_be)));
    b_req_valid = b_acc && (!b_we || ((WRITE_MODE == 0) && (|b_be) && !b_drop));
    a_req_data  = a_we ? a_merged : a_old;
    b_req_data  = b_we ? b_merged : b_old;
  end

  // First output stage; data only moves on valid so dout holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_valid <= 1'b0;
      b_s1_valid <= 1'b0;
      a_s1_data  <= '0;
      b_s1_data  <= '0;
      collision  <= 1'b0;
    end else begin
      a_s1_valid <= a_req_valid;
      b_s1_valid <= b_req_valid;
      collision  <= b_drop;
      if (a_req_valid) a_s1_data <= a_req_data;
      if (b_req_valid) b_s1_data <= b_req_data;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_valid <= 1'b0;
          b_valid <= 1'b0;
          a_dout  <= '0;
          b_dout  <= '0;
        end else begin
          a_valid <= a_s1_valid;
          b_valid <= b_s1_valid;
          if (a_s1_valid) a_dout <= a_s1_data;
          if (b_s1_valid) b_dout <= b_s1_data;
        end
      end
    end else begin : g_lat1
      assign a_valid = a_s1_valid;
      assign b_valid = b_s1_valid;
      assign a_dout  = a_s1_data;
      assign b_dout  = b_s1_data;
    end
  endgenerate

endmodule
